// File: rtl/uart_pkg.sv
// Shared types and constants for the UART framers.
// The majority helper turns three oversamples into one bit decision.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int OVERSAMPLE = 4;
  localparam int DATA_BITS  = 8;

  function automatic logic MAJ3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_framer_if.sv
// Byte-side handshake between the receive framer and its consumer
// (rx FIFO writer or CPU status logic).
interface uart_rx_framer_if;

  logic [uart_pkg::DATA_BITS-1:0] rx_byte;
  logic                           rx_valid;
  logic                           rx_ack;
  logic                           received;
  logic                           frame_error;
  logic                           overrun;
  logic                           is_receiving;

  modport master (
    output rx_byte, rx_valid, received, frame_error, overrun, is_receiving,
    input  rx_ack
  );

  modport slave (
    input  rx_byte, rx_valid, received, frame_error, overrun, is_receiving,
    output rx_ack
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running down-counter with a reload input
// so a framer can re-align the tick grid to a detected start edge.
module uart_baud_tick #(
  parameter int CLOCK_DIVIDE = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic i_reload,
  output logic o_tick
);

  localparam int CNT_W = (CLOCK_DIVIDE > 2) ? $clog2(CLOCK_DIVIDE) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(CLOCK_DIVIDE - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_reload || (r_count == '0)) begin
      r_count <= LOAD;
    end else begin
      r_count <= r_count - 1'b1;
    end
  end

  // A reload cycle never ticks, so the first tick lands a full period later.
  assign o_tick = (r_count == '0) && !i_reload;

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 receive framer: synchronises rx, oversamples each bit 4x, votes on the
// middle three samples and hands bytes out through a one-deep valid/ack register.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLOCK_DIVIDE = 651,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  uart_rx_framer_if.master rx_if
);

  localparam int PHASE_W = $clog2(OVERSAMPLE);
  localparam int IDX_W   = $clog2(DATA_BITS);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]   LAST_BIT   = IDX_W'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxs_prev;
  logic                   w_rxs;
  logic                   w_fall;
  logic                   w_tick;
  logic                   w_reload;
  logic                   w_maj;
  logic                   w_decide;
  logic [PHASE_W-1:0]     w_phase_new;

  rx_state_t              r_state, w_state_next;
  logic [PHASE_W-1:0]     r_phase, w_phase_next;
  logic [IDX_W-1:0]       r_bit_idx, w_bit_idx_next;
  logic [1:0]             r_samp, w_samp_next;
  logic [DATA_BITS-1:0]   r_shift, w_shift_next;
  logic [DATA_BITS-1:0]   r_byte, w_byte_next;
  logic                   r_valid, w_valid_next;
  logic                   r_received, w_received_next;
  logic                   r_frame_err, w_frame_err_next;
  logic                   r_overrun, w_overrun_next;
  logic                   r_busy, w_busy_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync     <= '1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], rx};
      r_rxs_prev <= w_rxs;
    end
  end

  assign w_rxs    = r_sync[SYNC_STAGES-1];
  assign w_fall   = r_rxs_prev & ~w_rxs;
  assign w_reload = (r_state == IDLE) && w_fall;

  uart_baud_tick #(
    .CLOCK_DIVIDE (CLOCK_DIVIDE)
  ) u_baud_tick (
    .clk      (clk),
    .rst      (rst),
    .i_reload (w_reload),
    .o_tick   (w_tick)
  );

  // r_phase counts ticks already elapsed in the bit; the tick that advances it
  // to 1, 2 or 3 takes a sample, and the one reaching 3 decides the bit.
  assign w_phase_new = r_phase + 1'b1;
  assign w_decide    = w_tick && (w_phase_new == LAST_PHASE);
  assign w_maj       = MAJ3(r_samp[0], r_samp[1], w_rxs);

  always_comb begin
    w_state_next     = r_state;
    w_phase_next     = r_phase;
    w_bit_idx_next   = r_bit_idx;
    w_samp_next      = r_samp;
    w_shift_next     = r_shift;
    w_byte_next      = r_byte;
    w_valid_next     = r_valid;
    w_received_next  = 1'b0;
    w_frame_err_next = 1'b0;
    w_overrun_next   = r_overrun;

    if (w_tick) begin
      w_phase_next = w_phase_new;
      if (w_phase_new == PHASE_W'(1)) w_samp_next[0] = w_rxs;
      if (w_phase_new == PHASE_W'(2)) w_samp_next[1] = w_rxs;
    end

    if (rx_if.rx_ack && r_valid) begin
      w_valid_next   = 1'b0;
      w_overrun_next = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_next   = START;
          w_phase_next   = '0;
          w_bit_idx_next = '0;
        end
      end
      START: begin
        if (w_decide) begin
          w_state_next   = w_maj ? IDLE : DATA;
          w_bit_idx_next = '0;
        end
      end
      DATA: begin
        if (w_decide) begin
          w_shift_next = {w_maj, r_shift[DATA_BITS-1:1]};
          if (r_bit_idx == LAST_BIT) begin
            w_state_next = STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_decide) begin
          if (w_maj) begin
            w_byte_next     = r_shift;
            w_valid_next    = 1'b1;
            w_received_next = 1'b1;
            // An unacked byte is being overwritten; a same-cycle ack consumed it.
            if (r_valid && !rx_if.rx_ack) w_overrun_next = 1'b1;
            w_state_next    = IDLE;
          end else begin
            w_frame_err_next = 1'b1;
            w_state_next     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (w_tick && w_rxs) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase

    w_busy_next = (w_state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_bit_idx   <= '0;
      r_samp      <= '0;
      r_shift     <= '0;
      r_byte      <= '0;
      r_valid     <= 1'b0;
      r_received  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_phase     <= w_phase_next;
      r_bit_idx   <= w_bit_idx_next;
      r_samp      <= w_samp_next;
      r_shift     <= w_shift_next;
      r_byte      <= w_byte_next;
      r_valid     <= w_valid_next;
      r_received  <= w_received_next;
      r_frame_err <= w_frame_err_next;
      r_overrun   <= w_overrun_next;
      r_busy      <= w_busy_next;
    end
  end

  assign rx_if.rx_byte      = r_byte;
  assign rx_if.rx_valid     = r_valid;
  assign rx_if.received     = r_received;
  assign rx_if.frame_error  = r_frame_err;
  assign rx_if.overrun      = r_overrun;
  assign rx_if.is_receiving = r_busy;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: directed scenarios plus random frames,
// compared against a frame-level model of the byte register and pulse counts.
module tb_uart_rx_framer;

  localparam int CD        = 4;
  localparam int BIT_CLK   = 4 * CD;
  localparam int FRAME_CLK = 10 * BIT_CLK;

  logic clk;
  logic rst;
  logic rx;

  uart_rx_framer_if u_if ();

  uart_rx_framer #(
    .CLOCK_DIVIDE (CD),
    .SYNC_STAGES  (2)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .rx_if (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int rcv_cnt = 0;
  int fe_cnt = 0;
  int frame_no = 0;

  // Frame-level reference state
  logic [7:0] m_byte;
  logic       m_valid;
  logic       m_ovr;
  int         exp_rcv;
  int         exp_fe;

  always @(negedge clk) begin
    if (u_if.received)    rcv_cnt++;
    if (u_if.frame_error) fe_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".rx_byte"},  32'(u_if.rx_byte),      32'(m_byte));
    check_eq({tag, ".rx_valid"}, 32'(u_if.rx_valid),     32'(m_valid));
    check_eq({tag, ".overrun"},  32'(u_if.overrun),      32'(m_ovr));
    check_eq({tag, ".received"}, 32'(rcv_cnt),           32'(exp_rcv));
    check_eq({tag, ".frm_err"},  32'(fe_cnt),            32'(exp_fe));
    check_eq({tag, ".busy"},     32'(u_if.is_receiving), 32'd0);
  endtask

  task automatic m_ack();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic m_good(input logic [7:0] b, input bit ack);
    if (m_valid) m_ovr = ack ? 1'b0 : 1'b1;
    m_byte  = b;
    m_valid = 1'b1;
    exp_rcv++;
  endtask

  task automatic idle_line(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
      u_if.rx_ack = 1'b0;
    end
  endtask

  task automatic hold_low(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b0;
    end
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    u_if.rx_ack = 1'b1;
    @(negedge clk);
    u_if.rx_ack = 1'b0;
    m_ack();
  endtask

  // Drives one 8N1 frame. ack_store raises rx_ack for the cycle that stores the
  // stop-bit decision; rst_at >= 0 pulses reset at that clock of the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit noise,
                            input bit ack_store, input int rst_at);
    logic [9:0] fr;
    int         bi;
    fr = {stop, b, 1'b0};
    for (int c = 0; c < FRAME_CLK; c++) begin
      @(negedge clk);
      bi = c / BIT_CLK;
      rx = fr[bi];
      if (noise && bi >= 1 && bi <= 8 && (c % BIT_CLK) == BIT_CLK / 2) rx = ~fr[bi];
      u_if.rx_ack = ack_store && (c == FRAME_CLK - 2);
      if (rst_at >= 0) begin
        if (c == rst_at) rst = 1'b0;
        if (c == rst_at + 4) begin
          check_eq("rst_mid.rx_byte",  32'(u_if.rx_byte),      32'd0);
          check_eq("rst_mid.rx_valid", 32'(u_if.rx_valid),     32'd0);
          check_eq("rst_mid.received", 32'(u_if.received),     32'd0);
          check_eq("rst_mid.frm_err",  32'(u_if.frame_error),  32'd0);
          check_eq("rst_mid.overrun",  32'(u_if.overrun),      32'd0);
          check_eq("rst_mid.busy",     32'(u_if.is_receiving), 32'd0);
        end
        if (c == rst_at + 8) rst = 1'b1;
      end
    end
    frame_no++;
    $display("frame %0d: byte=0x%02h stop=%0b noise=%0b ack_at_store=%0b reset_at=%0d",
             frame_no, b, stop, noise, ack_store, rst_at);
    if (rst_at >= 0) begin
      m_byte  = 8'h00;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else if (stop) begin
      m_good(b, ack_store);
    end else begin
      if (ack_store) m_ack();
      exp_fe++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [7:0] rb;
  logic       rstop;
  bit         rnoise;
  bit         rack;
  int         wait_cyc;

  initial begin
    rst = 1'b0;
    rx = 1'b1;
    u_if.rx_ack = 1'b0;
    m_byte = 8'h00;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    exp_rcv = 0;
    exp_fe = 0;

    repeat (3) @(negedge clk);
    check_eq("reset.rx_byte",  32'(u_if.rx_byte),      32'd0);
    check_eq("reset.rx_valid", 32'(u_if.rx_valid),     32'd0);
    check_eq("reset.received", 32'(u_if.received),     32'd0);
    check_eq("reset.frm_err",  32'(u_if.frame_error),  32'd0);
    check_eq("reset.overrun",  32'(u_if.overrun),      32'd0);
    check_eq("reset.busy",     32'(u_if.is_receiving), 32'd0);
    rst = 1'b1;
    idle_line(32);

    send_frame(8'h55, 1'b1, 1'b0, 1'b0, -1);
    idle_line(24);
    check_state("f55");

    send_frame(8'hA3, 1'b1, 1'b0, 1'b0, -1);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, -1);
    idle_line(24);
    check_state("b2b");
    pulse_ack();
    check_state("b2b_ack");

    hold_low(CD);
    idle_line(4 * BIT_CLK);
    check_state("glitch");

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
    hold_low(20 * BIT_CLK);
    check_eq("break.mid_frm_err", 32'(fe_cnt), 32'(exp_fe));
    check_eq("break.mid_busy", 32'(u_if.is_receiving), 32'd1);
    hold_low(20 * BIT_CLK);
    check_eq("break.end_frm_err", 32'(fe_cnt), 32'(exp_fe));
    check_eq("break.end_busy", 32'(u_if.is_receiving), 32'd1);
    wait_cyc = 0;
    while (u_if.is_receiving && wait_cyc < 200) begin
      idle_line(1);
      wait_cyc++;
    end
    check_eq("break.recover", 32'(u_if.is_receiving), 32'd0);
    idle_line(24);
    check_state("break");
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, -1);
    idle_line(24);
    check_state("f81");

    send_frame(8'hC6, 1'b1, 1'b1, 1'b0, -1);
    idle_line(24);
    check_state("noise");
    pulse_ack();

    send_frame(8'h77, 1'b1, 1'b0, 1'b0, -1);
    idle_line(24);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 5 * BIT_CLK + BIT_CLK / 2);
    idle_line(24);
    check_state("rst_mid");
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, -1);
    idle_line(24);
    check_state("f12");
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, -1);
    idle_line(24);
    check_state("ack_store");

    for (int i = 0; i < 30; i++) begin
      rb     = 8'($urandom_range(0, 255));
      rstop  = ($urandom_range(0, 4) != 0);
      rnoise = ($urandom_range(0, 1) != 0);
      rack   = ($urandom_range(0, 3) == 0);
      send_frame(rb, rstop, rnoise, rack, -1);
      idle_line($urandom_range(24, 48));
      check_state($sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) != 0) pulse_ack();
    end
    idle_line(4);
    check_state("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Standalone UART receive framer: deserialises 8N1 frames from the asynchronous `rx` line into bytes for the CPU-side UART controller and its rx FIFO.
- Uses 4x oversampling with 3-sample majority voting per bit.
- Holds each byte in a one-deep output register with a valid/ack handshake, plus sticky overrun and framing-error reporting.
- Counterpart to the transmit path: a downstream agent (rx FIFO writer or CPU status logic) drains bytes.

Parameters:
- CLOCK_DIVIDE, 651, clk cycles per oversample tick (CLOCK_FREQUENCY/(BAUD_RATE*4)); legal range >= 2.
- SYNC_STAGES, 2, flops in the rx metastability synchroniser; legal range >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  serial line, idles high.
- rx_ack  in  1  consumer accepts rx_byte; honoured only while rx_valid=1.
- rx_byte  out  8  last received byte.
- rx_valid  out  1  rx_byte holds an unconsumed byte.
- received  out  1  one-cycle pulse when a good frame completes.
- frame_error  out  1  one-cycle pulse when a stop bit is sampled low.
- overrun  out  1  sticky: a byte was overwritten before being acked.
- is_receiving  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - rx_byte=0, rx_valid=0, received=0, frame_error=0, overrun=0, is_receiving=0.
  - Synchroniser flops preset to 1; state=IDLE; divider=0; phase=0; bit index=0.
- Synchroniser: `rx` passes through SYNC_STAGES flops; only the synchronised value rxs is used.
- Tick generator:
  - Down-counter from CLOCK_DIVIDE-1 to 0; tick=1 in the cycle the count is 0, then reloads.
  - Forced to reload CLOCK_DIVIDE-1 (tick suppressed) on start detection.
- Bit timing:
  - Each bit spans 4 ticks, phase 0..3.
  - rxs is captured at phases 1, 2 and 3; the bit value is the majority of those three, decided on the phase-3 tick.
- State machine (IDLE, START, DATA, STOP, WAIT_IDLE):
  - IDLE: a falling edge of rxs (previous 1, current 0) -> START, with phase=0 and divider reloaded.
  - START: at phase 3, majority 0 -> DATA with bit index=0; majority 1 -> IDLE (false start; no outputs change).
  - DATA: at each phase 3, shift the majority bit in LSB-first. After bit 7 -> STOP.
  - STOP, majority 1 (good frame):
    - rx_byte <= shifted byte, rx_valid <= 1, received pulses 1 cycle -> IDLE.
    - If rx_valid was already 1 and rx_ack=0 in that cycle: overrun <= 1 and the new byte overwrites the old one.
  - STOP, majority 0: frame_error pulses 1 cycle; rx_byte and rx_valid are unchanged -> WAIT_IDLE.
  - WAIT_IDLE: stays until rxs=1 on a tick -> IDLE. A break (line held low) produces exactly one frame_error.
- Output timing: all outputs are registered. received and rx_valid become visible on the clk edge after the stop-bit phase-3 tick cycle.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid and overrun on the next edge.
  - rx_ack with rx_valid=0 is ignored.
  - rx_ack in the same cycle as a good-frame store: the new byte is loaded, rx_valid stays 1, overrun is cleared (ack consumed the old byte).
- The phase counter wraps 3->0 and the bit index saturates at 7; no arithmetic beyond these counters.
- Reset mid-frame: immediate return to IDLE. The partial byte is discarded and no pulses are emitted.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, WAIT_IDLE}.
  - OVERSAMPLE=4, DATA_BITS=8, and MAJ3 as a function.
- Sub-module uart_baud_tick: holds the divider plus reload input and emits tick. It is reusable by a future uart_tx_framer.

Test Plan (CLOCK_DIVIDE=4, so 16 clk per bit):
- Drive frame 0x55 (start, 10101010 LSB-first, stop) -> received pulses once, rx_byte=0x55, rx_valid=1, frame_error=0, is_receiving low afterwards.
- Drive 0xA3 then 0x0F back-to-back, no rx_ack -> after the 2nd frame rx_byte=0x0F, overrun=1; then pulse rx_ack -> rx_valid=0, overrun=0.
- 1-tick (4 clk) low glitch on idle rx -> START aborts to IDLE, no received, no frame_error, rx_valid stays 0.
- Frame 0x3C with stop bit low, then the line held low for 40 bit times -> exactly one frame_error pulse, rx_valid unchanged, is_receiving=1 until rx returns high, then the next frame 0x81 is received correctly.
- Single-sample noise: invert rx for 1 clk at phase 2 of each data bit of 0xC6 -> majority voting still yields rx_byte=0xC6.
- Assert rst low during data bit 4 of 0xFF, release, then send 0x12 -> only 0x12 is delivered, all outputs 0 during reset; also rx_ack coincident with the stop-bit store -> rx_valid stays 1, overrun=0.
